dmem_latency: RTL and testbench

- Parametrised data memory for the pipelined CPU. Successor to the single-cycle data memory.
- Adds a request/acknowledge handshake and a configurable access latency of LATENCY cycles.
- Adds per-byte write enables and range/alignment error reporting.
- Sits behind the MEM stage. The stage stalls while busy_o is high; the port is later reused behind a cache.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_latency_ctr.sv | 40 ++++
 rtl/dmem_latency.sv | 151 +++++++++++++++
 tb/tb_dmem_latency.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the latency-configurable data memory.
// Used by dmem_latency and its down-counter.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CTR_W       = 4;
  localparam int MAX_LATENCY = (1 << CTR_W) - 1;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

  // Any set bit below the word offset, or at/above the top of the array, is an error.
  function automatic logic addr_err(input logic [63:0] addr, input int addr_w,
                                    input int ob, input int iw);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < addr_w && addr[i] && (i < ob || i >= ob + iw)) begin
        e = 1'b1;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// Loadable down-counter with zero flag; shared with the future cache miss path.
// Counting stops at zero; load has priority over enable.
module dmem_latency_ctr
  import dmem_pkg::*;
#(
  parameter int W = CTR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/dmem_latency.sv
// Data memory with req/ack handshake, LATENCY-cycle access, byte enables and error reporting.
// Optional macro DMEM_FAST_READ_EN: reads complete the cycle after acceptance.
module dmem_latency
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  localparam int NB = lane_count(DATA_W);
  localparam int OB = off_bits(DATA_W);
  localparam int IW = idx_bits(DEPTH);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_latency: LATENCY must be in 1..15");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
    $error("dmem_latency: DATA_W must be a multiple of 8, at least 8");
  end
  if (DEPTH < 2 || (1 << IW) != DEPTH) begin : g_bad_depth
    $error("dmem_latency: DEPTH must be a power of 2, at least 2");
  end

  // Handshake: a request is taken on any edge where req_i is high and the
  // FSM is in IDLE or DONE; ack_o then pulses for one cycle per request.
  state_e            state_q, state_d;
  logic              we_q, err_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, do_access, fast_rd;
  logic              ctr_load, ctr_en, ctr_zero;
  logic [CTR_W-1:0]  ctr_count;
  logic              in_err;
  logic [IW-1:0]     idx_in;

  assign in_err = addr_err(64'(addr_i), ADDR_W, OB, IW);
  assign idx_in = addr_i[OB +: IW];

`ifdef DMEM_FAST_READ_EN
  assign fast_rd = req_i && !we_i && (state_q != ST_BUSY);
`else
  assign fast_rd = 1'b0;
`endif

  dmem_latency_ctr #(.W(CTR_W)) u_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ctr_load),
    .load_val_i (CTR_W'(LATENCY - 1)),
    .en_i       (ctr_en),
    .count_o    (ctr_count),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Leaving DONE with req_i high starts the next access with no idle gap.
        if (req_i) begin
          accept   = 1'b1;
          ctr_load = 1'b1;
          state_d  = fast_rd ? ST_DONE : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ctr_zero) begin
          do_access = 1'b1;
          state_d   = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= we_i;
        err_q   <= in_err;
        idx_q   <= idx_in;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      // A successful write leaves rdata_q holding the previous read.
      if (do_access) begin
        if (err_q) begin
          rdata_q <= '0;
        end else if (!we_q) begin
          rdata_q <= mem_q[idx_q];
        end
      end else if (fast_rd) begin
        rdata_q <= in_err ? '0 : mem_q[idx_in];
      end
    end
  end

  // The array has no reset; do_access is low while rst_i is asserted.
  always_ff @(posedge clk_i) begin
    if (do_access && we_q && !err_q) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) begin
          mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign ack_o       = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_DONE) && err_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_latency.sv
// Bench for dmem_latency: reset, directed table, reset abort, held requests, random traffic.
// Instance 0 uses default parameters, instance 1 uses LATENCY=2.
module tb_dmem_latency;
  import dmem_pkg::*;

  localparam int LAT_A = 4;
  localparam int LAT_B = 2;
`ifdef DMEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];
  logic        busy_v  [2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];
  logic [1:0]  st_v    [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [2][32];
  logic [31:0] model_rd  [2];

  always #5 clk = ~clk;

  dmem_latency u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_v[0]), .we_i(we_v[0]), .addr_i(addr_v[0]),
    .wdata_i(wdata_v[0]), .be_i(be_v[0]), .busy_o(busy_v[0]), .ack_o(ack_v[0]),
    .rdata_o(rdata_v[0]), .err_o(err_v[0]), .dbg_state_o(st_v[0])
  );

  dmem_latency #(.LATENCY(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_v[1]), .we_i(we_v[1]), .addr_i(addr_v[1]),
    .wdata_i(wdata_v[1]), .be_i(be_v[1]), .busy_o(busy_v[1]), .ack_o(ack_v[1]),
    .rdata_o(rdata_v[1]), .err_o(err_v[1]), .dbg_state_o(st_v[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int s, input logic w);
    int l;
    l = (s == 0) ? LAT_A : LAT_B;
    return (w || !FAST) ? l + 1 : 1;
  endfunction

  // Reference model: word array per instance, held read data, plain arithmetic for errors.
  task automatic model_step(input int s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output logic [31:0] exp_rd, output logic exp_e);
    exp_e = (a % 4 != 0) || (a >= 32 * 4);
    if (exp_e) begin
      model_rd[s] = 32'h0;
    end else if (w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) model_mem[s][a / 4][8*k +: 8] = d[8*k +: 8];
    end else begin
      model_rd[s] = model_mem[s][a / 4];
    end
    exp_rd = model_rd[s];
  endtask

  // Called at a negedge; returns at the negedge where ack_o was seen.
  task automatic access(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e, output int lat);
    logic busy_ok;
    req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d; be_v[s] = b;
    @(posedge clk);
    #1 req_v[s] = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!busy_v[s]) busy_ok = 1'b0;
      if (ack_v[s]) begin
        lat = k;
        break;
      end
    end
    rd = rdata_v[s];
    e  = err_v[s];
    chk("busy_during_access", 64'(busy_ok), 64'(1));
  endtask

  task automatic run_check(input int s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, input string nm);
    logic [31:0] exp_rd, rd;
    logic        exp_e, e;
    int          lat;
    model_step(s, w, a, d, b, exp_rd, exp_e);
    access(s, w, a, d, b, rd, e, lat);
    chk({nm, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({nm, "_err"}, 64'(e), 64'(exp_e));
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat(s, w)));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, tmp_rd;
    logic        e, tmp_e, busy_ok, no_ack;
    int          lat, n_ack, rd_addr;

    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'h5, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h08, 32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h08, 32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0};
    vecs[6]  = '{1'b1, 32'h0C, 32'h00000000, 4'hF, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h0C, 32'hA5A5A5A5, 4'hA, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h0C, 32'h0,        4'hF, 1'b1, 32'hA500A500, 1'b0};
    vecs[9]  = '{1'b0, 32'h0A, 32'h0,        4'hF, 1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h80, 32'h0,        4'hF, 1'b1, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 32'h10000000, 32'h12345678, 4'hF, 1'b1, 32'h0,  1'b1};
    vecs[13] = '{1'b0, 32'h08, 32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0};

    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wdata_v[s] = '0; be_v[s] = '0;
      model_rd[s] = 32'h0;
    end

    // Reset
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy",  64'(busy_v[0]),  64'(0));
    chk("reset_ack",   64'(ack_v[0]),   64'(0));
    chk("reset_rdata", 64'(rdata_v[0]), 64'(0));
    chk("reset_err",   64'(err_v[0]),   64'(0));
    chk("reset_state", 64'(st_v[0]),    64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Initialise every word of instance A
    for (int i = 0; i < 32; i++) run_check(0, 1'b1, 32'(i * 4), $urandom, 4'hF, "init_wr");

    // Directed table
    for (int i = 0; i < 14; i++) begin
      model_step(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, tmp_rd, tmp_e);
      access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, e, lat);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(0, vecs[i].we)));
    end

    // Error writes must leave the whole array untouched
    for (int i = 0; i < 32; i++) run_check(0, 1'b0, 32'(i * 4), 32'h0, 4'hF, "sweep_rd");

    // Reset during BUSY of a write to 0x04
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h04; wdata_v[0] = 32'hFFFFFFFF; be_v[0] = 4'hF;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 64'(busy_v[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  64'(busy_v[0]),  64'(0));
    chk("abort_ack",   64'(ack_v[0]),   64'(0));
    chk("abort_rdata", 64'(rdata_v[0]), 64'(0));
    chk("abort_err",   64'(err_v[0]),   64'(0));
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    no_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_v[0]) no_ack = 1'b0;
      if (k == 2) rst_n = 1'b1;
    end
    chk("abort_no_ack", 64'(no_ack), 64'(1));
    run_check(0, 1'b0, 32'h04, 32'h0, 4'hF, "abort_rd04");

    // Held request on instance B: three back-to-back reads
    for (int i = 0; i < 3; i++) run_check(1, 1'b1, 32'(i * 4), $urandom, 4'hF, "b_init_wr");
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h0; be_v[1] = 4'hF;
    rd_addr = 0;
    @(posedge clk);
    n_ack = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 3 * exp_lat(1, 1'b0) + 4; k++) begin
      @(negedge clk);
      if (ack_v[1]) begin
        model_step(1, 1'b0, 32'(rd_addr), 32'h0, 4'hF, exp_rd, tmp_e);
        chk($sformatf("held_ack%0d_pos", n_ack), 64'(k), 64'((n_ack + 1) * exp_lat(1, 1'b0)));
        chk($sformatf("held_ack%0d_rdata", n_ack), 64'(rdata_v[1]), 64'(exp_rd));
        n_ack++;
        rd_addr += 4;
        if (n_ack == 3) req_v[1] = 1'b0;
        we_v[1] = 1'b0; addr_v[1] = 32'(rd_addr);
      end else if (n_ack < 3) begin
        if (!busy_v[1]) busy_ok = 1'b0;
        we_v[1] = 1'b1; addr_v[1] = 32'h0; wdata_v[1] = 32'hBAD0BAD0;
      end
    end
    chk("held_ack_count", 64'(n_ack), 64'(3));
    chk("held_busy", 64'(busy_ok), 64'(1));
    for (int i = 0; i < 3; i++) run_check(1, 1'b0, 32'(i * 4), 32'h0, 4'hF, "b_post_rd");

    // Random traffic on instance A
    for (int i = 0; i < 60; i++) begin
      logic        w;
      logic [31:0] a;
      int          r;
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 127));
      else if (r == 1) a = 32'(128 + $urandom_range(0, 1000) * 4);
      else             a = 32'($urandom_range(0, 31) * 4);
      run_check(0, w, a, $urandom, 4'($urandom_range(0, 15)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
